imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into N-bit words
// and writes them into a 64-word register file that the processor reads combinationally.
module imem_loader #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  input  logic         byte_last,
  output logic         byte_ready,
  input  logic [5:0]   rd_addr,
  output logic [N-1:0] q,
  output logic         loading,
  output logic         done,
  output logic [6:0]   word_count
);

  localparam int BYTES = N / 8;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [5:0]     ptr_q, ptr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   asm_q, asm_d;
  logic [6:0]     cnt_q, cnt_d;
  logic [N-1:0]   ram_q [64];

  logic           accept_s;
  logic           we_s;
  logic [N-1:0]   wr_word_s;

  // Status outputs decode directly from the state register.
  assign byte_ready = (state_q == LOAD);
  assign loading    = (state_q == LOAD);
  assign done       = (state_q == DONE);
  assign word_count = cnt_q;
  assign q          = ram_q[rd_addr];

  // Next-state and datapath decode; bytes above the current index stay zero, which gives the
  // zero-fill for a short final word.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    cnt_d     = cnt_q;
    we_s      = 1'b0;
    accept_s  = (state_q == LOAD) && byte_valid;
    wr_word_s = asm_q;
    for (int k = 0; k < BYTES; k++) begin
      wr_word_s[8*k +: 8] = (idx_q == IW'(k)) ? byte_data : asm_q[8*k +: 8];
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          ptr_d   = 6'd0;
          idx_d   = '0;
          asm_d   = '0;
          cnt_d   = 7'd0;
        end else begin
          state_d = state_q;
        end
      end
      LOAD: begin
        if (accept_s && ((idx_q == IW'(BYTES - 1)) || byte_last)) begin
          we_s  = 1'b1;
          ptr_d = ptr_q + 6'd1;
          cnt_d = cnt_q + 7'd1;
          idx_d = '0;
          asm_d = '0;
          if (byte_last || (ptr_q == 6'd63)) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end else if (accept_s) begin
          asm_d = wr_word_s;
          idx_d = idx_q + IW'(1);
        end else begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and assembly registers; reset wins over start and over any byte acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 6'd0;
      idx_q   <= '0;
      asm_q   <= '0;
      cnt_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
    end
  end

  // Word storage: a same-cycle read returns the old word because the write lands at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) begin
        ram_q[i] <= '0;
      end
    end else if (we_s) begin
      ram_q[ptr_q] <= wr_word_s;
    end else begin
      ram_q[ptr_q] <= ram_q[ptr_q];
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expectations into queues, independent
// monitors pop and compare on read strobes, status strobes and rising done.
module tb_imem_loader;

  localparam int N     = 32;
  localparam int BYTES = N / 8;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [6:0] wc;
    logic       dn;
    logic       rdy;
    logic       ld;
  } st_t;

  logic         clk = 1'b0;
  logic         reset, start, byte_valid, byte_last;
  logic [7:0]   byte_data;
  logic         byte_ready, loading, done;
  logic [5:0]   rd_addr;
  logic [N-1:0] q;
  logic [6:0]   word_count;

  logic         rd_req, st_req;
  logic [N-1:0] rd_q[$];
  st_t          st_q[$];
  logic [6:0]   done_q[$];
  logic [N-1:0] ram_m [64];
  int           checks = 0;
  int           errors = 0;

  imem_loader #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
    .rd_addr(rd_addr), .q(q), .loading(loading), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: word w of an image is bytes w*BYTES.. packed little-endian, zero beyond the end.
  function automatic logic [N-1:0] word_of(input bq_t b, input int w);
    logic [N-1:0] r = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (w * BYTES + k < b.size()) r = r | (N'(b[w * BYTES + k]) << (8 * k));
    end
    return r;
  endfunction

  // Read monitor.
  initial forever begin
    @(negedge clk);
    if (rd_req) begin
      if (rd_q.size() == 0) chk("rd_underflow", 64'd1, 64'd0);
      else chk($sformatf("q[%0d]", rd_addr), 64'(q), 64'(rd_q.pop_front()));
    end
  end

  // Status monitor.
  initial forever begin
    @(negedge clk);
    if (st_req) begin
      if (st_q.size() == 0) chk("st_underflow", 64'd1, 64'd0);
      else chk("status{wc,done,ready,loading}",
               64'({word_count, done, byte_ready, loading}), 64'(st_q.pop_front()));
    end
  end

  // Done-edge monitor: every completed load presents its final word_count.
  initial begin
    logic done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (done_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else chk("done_word_count", 64'(word_count), 64'(done_q.pop_front()));
      end
      done_prev = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk); #1;
    byte_valid = 1'b0; byte_last = 1'b0; start = 1'b0;
  endtask

  task automatic strobe(input st_t e);
    cyc(); st_q.push_back(e); st_req = 1'b1;
    cyc(); st_req = 1'b0;
  endtask

  task automatic sweep();
    for (int a = 0; a < 64; a++) begin
      cyc(); rd_addr = 6'(a); rd_q.push_back(ram_m[a]); rd_req = 1'b1;
    end
    cyc(); rd_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic lst, input int vprob);
    int  tries = 0;
    logic acc = 1'b0;
    while (!acc) begin
      @(posedge clk); #1;
      start      = 1'b0;
      byte_valid = ($urandom_range(0, 99) < vprob);
      byte_data  = d;
      byte_last  = lst;
      acc        = byte_valid && byte_ready;
      tries++;
      if (tries > 200) begin
        chk("byte_accept_timeout", 64'd0, 64'd1);
        acc = 1'b1;
      end
    end
  endtask

  task automatic do_load(input bq_t b, input logic last, input int vprob,
                         input int mid_start, input int watch);
    int nb    = b.size();
    int words = (nb + BYTES - 1) / BYTES;
    if (words > 64) words = 64;
    done_q.push_back(7'(words));
    cyc(); start = 1'b1;
    cyc();
    for (int i = 0; i < nb; i++) begin
      logic lst = last && (i == nb - 1);
      if (i == mid_start) begin
        cyc(); start = 1'b1;
        cyc();
      end
      if (i == watch) begin
        cyc();
        byte_valid = 1'b1; byte_data = b[i]; byte_last = lst;
        rd_addr = 6'(i / BYTES); rd_q.push_back(ram_m[i / BYTES]); rd_req = 1'b1;
        chk("watch_ready", 64'(byte_ready), 64'd1);
        cyc();
        rd_q.push_back(word_of(b, i / BYTES));
      end else begin
        send_byte(b[i], lst, vprob);
      end
    end
    cyc(); rd_req = 1'b0;
    for (int w = 0; w < words; w++) ram_m[w] = word_of(b, w);
    strobe('{wc: 7'(words), dn: 1'b1, rdy: 1'b0, ld: 1'b0});
  endtask

  task automatic clear_model();
    for (int a = 0; a < 64; a++) ram_m[a] = '0;
  endtask

  initial begin
    bq_t b;
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
    byte_data = 8'h00; rd_addr = 6'd0; rd_req = 1'b0; st_req = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    strobe('{wc: 7'd0, dn: 1'b0, rdy: 1'b0, ld: 1'b0});
    sweep();

    // Two full words from a fixed image.
    b = '{8'h00, 8'h00, 8'h00, 8'hf8, 8'h01, 8'h80, 8'h00, 8'hf8};
    do_load(b, 1'b1, 100, -1, -1);
    chk("ram0_fixed", 64'(ram_m[0]), 64'(32'hf8000000));
    sweep();

    // Short last word is zero-filled.
    b = '{8'h4e, 8'h00};
    do_load(b, 1'b1, 100, -1, -1);
    sweep();

    // Full 64-word image with a randomly gapped valid; later bytes must be refused.
    b = {};
    for (int i = 0; i < 64 * BYTES; i++) b.push_back(8'($urandom));
    do_load(b, 1'b0, 60, -1, -1);
    repeat (3) begin
      @(posedge clk); #1; byte_valid = 1'b1; byte_data = 8'($urandom); byte_last = 1'b0;
    end
    strobe('{wc: 7'd64, dn: 1'b1, rdy: 1'b0, ld: 1'b0});
    sweep();

    // Reset mid-load, with start and a valid byte in the same cycle.
    cyc(); start = 1'b1;
    cyc();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0, 100);
    strobe('{wc: 7'(6 / BYTES), dn: 1'b0, rdy: 1'b1, ld: 1'b1});
    cyc(); reset = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_data = 8'h5a;
    cyc(); reset = 1'b0;
    clear_model();
    strobe('{wc: 7'd0, dn: 1'b0, rdy: 1'b0, ld: 1'b0});
    sweep();
    b = '{8'hce, 8'h01, 8'h0e, 8'hcb};
    do_load(b, 1'b1, 100, -1, -1);
    chk("ram0_after_reset", 64'(ram_m[0]), 64'(32'hcb0e01ce));
    sweep();

    // Three-word load, then a one-word load with start pulsed mid-load.
    b = {};
    for (int i = 0; i < 3 * BYTES; i++) b.push_back(8'($urandom));
    do_load(b, 1'b1, 80, -1, -1);
    b = {};
    for (int i = 0; i < BYTES; i++) b.push_back(8'($urandom));
    do_load(b, 1'b1, 80, BYTES / 2, -1);
    sweep();

    // Read word 5 in the very cycle it is written.
    b = {};
    for (int i = 0; i < 6 * BYTES; i++) b.push_back(8'($urandom));
    do_load(b, 1'b1, 100, -1, 6 * BYTES - 1);
    sweep();

    // Random-length images.
    repeat (4) begin
      b = {};
      for (int i = 0; i < $urandom_range(1, 30); i++) b.push_back(8'($urandom));
      do_load(b, 1'b1, 70, -1, -1);
      sweep();
    end

    repeat (2) cyc();
    chk("queues_drained", 64'(rd_q.size() + st_q.size() + done_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
